// File: rtl/axi_sram_read_slave.sv
// AXI4 read-channel responder for a single-port synchronous SRAM.
// One burst in flight; every beat costs a fetch cycle plus a response cycle.
module axi_sram_read_slave #(
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int MEM_AW    = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDS_BITS-1:0]  ARID_S,
    input  logic [ADDR_BITS-1:0] ARADDR,
    input  logic [LEN_BITS-1:0]  ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [IDS_BITS-1:0]  RID_S,
    output logic [DATA_BITS-1:0] RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY,
    output logic                 sram_cs,
    output logic [MEM_AW-1:0]    sram_addr,
    input  logic [DATA_BITS-1:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    localparam logic [MEM_AW-1:0]   ONE_WORD = 1;
    localparam logic [LEN_BITS-1:0] ONE_BEAT = 1;
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;

    state_t               state_reg;
    logic                 arready_reg;
    logic                 rvalid_reg;
    logic                 rlast_reg;
    logic [IDS_BITS-1:0]  rid_reg;
    logic [DATA_BITS-1:0] rdata_reg;
    logic [1:0]           rresp_reg;
    logic [LEN_BITS-1:0]  len_reg;
    logic [LEN_BITS-1:0]  count_reg;
    logic                 incr_reg;
    logic                 err_reg;
    logic [MEM_AW-1:0]    addr_reg;
    logic [MEM_AW-1:0]    addr_next;

    logic ar_hs;
    logic r_hs;
    logic req_err;
    logic unused_addr_bits;

    assign ar_hs   = ARVALID && arready_reg;
    assign r_hs    = rvalid_reg && RREADY;
    // Only FIXED (00) and INCR (01) with 4-byte beats are served.
    assign req_err = (ARSIZE != 3'b010) || ARBURST[1];
    // INCR wraps naturally at the top of the SRAM word space.
    assign addr_next = incr_reg ? addr_reg + ONE_WORD : addr_reg;

    assign unused_addr_bits = &{1'b0, ARADDR[ADDR_BITS-1:MEM_AW+2], ARADDR[1:0]};

    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign RLAST   = rlast_reg;
    assign RID_S   = rid_reg;
    assign RDATA   = rdata_reg;
    assign RRESP   = rresp_reg;

    // Reads are launched a cycle early so the data lands as FETCH is entered.
    always_comb begin
        sram_cs   = 1'b0;
        sram_addr = addr_reg;
        case (state_reg)
            IDLE: begin
                sram_cs   = ARVALID;
                sram_addr = ARADDR[MEM_AW+1:2];
            end
            RESP: begin
                sram_cs   = r_hs && !rlast_reg && !err_reg;
                sram_addr = addr_next;
            end
            default: begin
                sram_cs   = 1'b0;
                sram_addr = addr_reg;
            end
        endcase
        if (rst) begin
            sram_cs = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rid_reg     <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            len_reg     <= '0;
            count_reg   <= '0;
            incr_reg    <= 1'b0;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ar_hs) begin
                        rid_reg     <= ARID_S;
                        len_reg     <= ARLEN;
                        incr_reg    <= ARBURST[0];
                        err_reg     <= req_err;
                        addr_reg    <= ARADDR[MEM_AW+1:2];
                        count_reg   <= '0;
                        arready_reg <= 1'b0;
                        state_reg   <= FETCH;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                FETCH: begin
                    rdata_reg  <= err_reg ? '0 : sram_rdata;
                    rresp_reg  <= err_reg ? RESP_SLVERR : RESP_OKAY;
                    rvalid_reg <= 1'b1;
                    rlast_reg  <= (count_reg == len_reg);
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (r_hs) begin
                        rvalid_reg <= 1'b0;
                        rlast_reg  <= 1'b0;
                        if (rlast_reg) begin
                            arready_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            addr_reg  <= addr_next;
                            count_reg <= count_reg + ONE_BEAT;
                            state_reg <= FETCH;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
